binary_stream_gen: RTL and testbench

Source-side generator for the binary pixel-stream interface consumed by the morphology blocks (dilate/erode chain). Produces data/valid/hs/vs with programmable raster timing and a selectable binary test pattern, so morphology pipelines can be driven on-chip and in simulation without a camera front end. Runs continuously frame after frame while enabled and stops only at a frame boundary.

---
 rtl/binary_video_pkg.sv | 25 ++
 rtl/binary_stream_gen_if.sv | 20 ++
 rtl/video_timing_counter.sv | 56 +++++
 rtl/binary_stream_gen.sv | 134 +++++++++++++
 tb/tb_binary_stream_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/binary_video_pkg.sv
// Shared constants for binary video sources: pattern codes, LFSR seed/taps, FSM encoding.
// Pure definitions, no timing or flow control.
package binary_video_pkg;

  localparam logic [2:0] PAT_ZERO  = 3'd0;
  localparam logic [2:0] PAT_ONE   = 3'd1;
  localparam logic [2:0] PAT_CHECK = 3'd2;
  localparam logic [2:0] PAT_DOT   = 3'd3;
  localparam logic [2:0] PAT_LFSR  = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/binary_stream_gen_if.sv
// Binary pixel-stream bundle between a stream source and the morphology chain.
// No handshake: the sink must accept every cycle.
interface binary_stream_gen_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_hs;
  logic                  data_out_vs;
  logic                  frame_done;
  logic [15:0]           frame_cnt;
  logic                  busy;

  modport master (
    output data_out, data_out_valid, data_out_hs, data_out_vs, frame_done, frame_cnt, busy
  );
  modport slave (
    input  data_out, data_out_valid, data_out_hs, data_out_vs, frame_done, frame_cnt, busy
  );
endinterface

// File: rtl/video_timing_counter.sv
// Raster h/v counters with active/sync/last region decode; flags are combinational from
// the counters. Counters advance only when 'advance' is high and are held at 0 by 'clear'.
module video_timing_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          clear,
  input  logic          advance,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_active,
  output logic          v_active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          last
);
  localparam logic [HW-1:0] H_LAST     = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign h_active = (h_cnt < H_ACT_END);
  assign v_active = (v_cnt < V_ACT_END);
  assign h_sync   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_sync   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign last     = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/binary_stream_gen.sv
// Free-running binary test-pattern raster source; first pixel 2 cycles after enable,
// outputs registered 1 cycle behind the counters. No backpressure; stops only at frame end.
module binary_stream_gen
  import binary_video_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CELL_LOG2  = 3,
  parameter int DOT_X      = 0,
  parameter int DOT_Y      = 0
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                enable,
  input  logic [2:0]          pattern_sel,
  binary_stream_gen_if.master vid
);
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  state_t        state, state_next;
  logic          busy_q;
  logic [2:0]    pat_q;
  logic [15:0]   lfsr;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_active, v_active, h_sync, v_sync, last;
  logic          stream, active, at_last, frame_start, pix;

  // The counters start one cycle after leaving IDLE, giving the two-cycle enable-to-pixel latency.
  assign stream  = busy_q && (state != ST_IDLE);
  assign active  = h_active && v_active;
  assign at_last = stream && last;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset_p(reset_p), .clear(state == ST_IDLE), .advance(stream),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .h_active(h_active), .v_active(v_active),
    .h_sync(h_sync), .v_sync(v_sync), .last(last)
  );

  always_ff @(posedge clk) begin
    if (reset_p) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next  = ST_RUN;
          frame_start = 1'b1;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (at_last) begin
          state_next  = enable ? ST_RUN : ST_IDLE;
          frame_start = enable;
        end else begin
          state_next  = enable ? ST_RUN : ST_STOPPING;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pix = 1'b0;
    case (pat_q)
      PAT_ONE:   pix = 1'b1;
      PAT_CHECK: pix = h_cnt[CELL_LOG2] ^ v_cnt[CELL_LOG2];
      PAT_DOT:   pix = (h_cnt == HW'(DOT_X)) && (v_cnt == VW'(DOT_Y));
      PAT_LFSR:  pix = lfsr[0];
      default:   pix = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      busy_q <= 1'b0;
      pat_q  <= PAT_ZERO;
      lfsr   <= LFSR_SEED;
    end else begin
      busy_q <= (state != ST_IDLE);
      if (frame_start) begin
        pat_q <= pattern_sel;
        lfsr  <= LFSR_SEED;
      end else if (stream && active) begin
        lfsr <= lfsr_next(lfsr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      vid.data_out       <= '0;
      vid.data_out_valid <= 1'b0;
      vid.data_out_hs    <= ~HS_POL;
      vid.data_out_vs    <= ~VS_POL;
      vid.frame_done     <= 1'b0;
      vid.frame_cnt      <= 16'd0;
    end else if (stream) begin
      vid.data_out       <= {DATA_WIDTH{pix && active}};
      vid.data_out_valid <= active;
      vid.data_out_hs    <= h_sync ? HS_POL : ~HS_POL;
      vid.data_out_vs    <= v_sync ? VS_POL : ~VS_POL;
      vid.frame_done     <= last;
      if (last) vid.frame_cnt <= vid.frame_cnt + 16'd1;
    end else begin
      vid.data_out       <= '0;
      vid.data_out_valid <= 1'b0;
      vid.data_out_hs    <= ~HS_POL;
      vid.data_out_vs    <= ~VS_POL;
      vid.frame_done     <= 1'b0;
    end
  end

  assign vid.busy = busy_q;

endmodule

// File: tb/tb_binary_stream_gen.sv
// Bench for binary_stream_gen: raster-level reference model checked every cycle, plus
// directed scenarios with hand-derived literals, then randomized enable/pattern/reset.
module tb_binary_stream_gen;
  localparam int HA = 8, HF = 2, H_SY = 2, HB = 2;
  localparam int VA = 6, VF = 1, V_SY = 1, VB = 1;
  localparam int HT = HA + HF + H_SY + HB;
  localparam int VT = VA + VF + V_SY + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] pattern_sel = 3'd0;

  binary_stream_gen_if #(.DATA_WIDTH(1)) vif ();

  binary_stream_gen #(
    .DATA_WIDTH(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CELL_LOG2(1), .DOT_X(3), .DOT_Y(2)
  ) dut (
    .clk(clk), .reset_p(reset_p), .enable(enable), .pattern_sel(pattern_sel), .vid(vif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: modes idle / warm-up (one cycle) / streaming raster positions.
  bit   lfsr_bits [HA*VA];
  int   m_mode = 0;
  int   m_pos = 0;
  int   m_pat = 0;
  bit   model_ready = 0;
  logic e_data, e_valid, e_hs, e_vs, e_done, e_busy;
  logic [15:0] e_cnt;

  initial begin
    int s;
    int fb;
    s = 16'hACE1;
    for (int k = 0; k < HA*VA; k++) begin
      lfsr_bits[k] = s[0];
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s = (s >> 1) | (fb << 15);
    end
  end

  function automatic bit model_pix(input int pat, input int x, input int y);
    case (pat)
      1: return 1'b1;
      2: return ((x / 2) % 2) != ((y / 2) % 2);
      3: return (x == 3) && (y == 2);
      4: return lfsr_bits[y*HA + x];
      default: return 1'b0;
    endcase
  endfunction

  task automatic exp_idle();
    e_data = 0; e_valid = 0; e_hs = 0; e_vs = 0; e_done = 0;
  endtask

  always @(posedge clk) begin
    int x;
    int y;
    if (reset_p) begin
      m_mode = 0; m_pos = 0; e_cnt = 16'd0; e_busy = 0;
      exp_idle();
    end else begin
      case (m_mode)
        0: begin
          exp_idle(); e_busy = 0;
          if (enable) begin m_mode = 1; m_pat = int'(pattern_sel); end
        end
        1: begin
          exp_idle(); e_busy = 1; m_mode = 2; m_pos = 0;
        end
        default: begin
          x = m_pos % HT; y = m_pos / HT;
          e_busy  = 1;
          e_valid = (x < HA) && (y < VA);
          e_data  = e_valid && model_pix(m_pat, x, y);
          e_hs    = (x >= HA + HF) && (x < HA + HF + H_SY);
          e_vs    = (y >= VA + VF) && (y < VA + VF + V_SY);
          e_done  = (m_pos == FRAME - 1);
          if (m_pos == FRAME - 1) begin
            e_cnt = e_cnt + 16'd1;
            if (enable) begin m_pos = 0; m_pat = int'(pattern_sel); end
            else m_mode = 0;
          end else begin
            m_pos++;
          end
        end
      endcase
    end
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("data_out", 32'(vif.data_out), 32'(e_data));
      chk("valid", 32'(vif.data_out_valid), 32'(e_valid));
      chk("hs", 32'(vif.data_out_hs), 32'(e_hs));
      chk("vs", 32'(vif.data_out_vs), 32'(e_vs));
      chk("frame_done", 32'(vif.frame_done), 32'(e_done));
      chk("frame_cnt", 32'(vif.frame_cnt), 32'(e_cnt));
      chk("busy", 32'(vif.busy), 32'(e_busy));
    end
  end

  // Per-frame observation results.
  int r_first_busy, r_first_valid, r_done_at, r_nvalid, r_nones, r_nhs, r_nvs;
  logic [47:0] r_bits;

  task automatic measure_frame(input int change_at, input logic [2:0] new_sel, input int drop_at);
    bit seen_done;
    seen_done = 0;
    r_first_busy = -1; r_first_valid = -1; r_done_at = -1;
    r_nvalid = 0; r_nones = 0; r_nhs = 0; r_nvs = 0; r_bits = '0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      tick();
      if (vif.busy && r_first_busy < 0) r_first_busy = c;
      if (vif.data_out_hs) r_nhs++;
      if (vif.data_out_vs) r_nvs++;
      if (vif.data_out_valid) begin
        if (r_first_valid < 0) r_first_valid = c;
        if (r_nvalid < 48) r_bits[r_nvalid] = vif.data_out[0];
        if (vif.data_out[0]) r_nones++;
        r_nvalid++;
        if (r_nvalid == change_at) pattern_sel = new_sel;
        if (r_nvalid == drop_at) enable = 1'b0;
      end
      if (vif.frame_done) begin seen_done = 1; r_done_at = c; end
    end
    chk("frame_done_seen", 32'(seen_done), 32'd1);
  endtask

  initial begin
    int nv;
    repeat (3) tick();
    chk("rst_valid", 32'(vif.data_out_valid), 0);
    chk("rst_hs", 32'(vif.data_out_hs), 0);
    chk("rst_busy", 32'(vif.busy), 0);
    chk("rst_frame_cnt", 32'(vif.frame_cnt), 0);
    reset_p = 1'b0;
    tick();

    // Checkerboard frame from idle: latency, raster shape, line data.
    pattern_sel = 3'd2; enable = 1'b1;
    measure_frame(-1, 3'd0, -1);
    chk("A_first_busy", r_first_busy, 1);
    chk("A_first_valid", r_first_valid, 2);
    chk("A_done_at", r_done_at, 127);
    chk("A_nvalid", r_nvalid, 48);
    chk("A_nhs", r_nhs, 18);
    chk("A_nvs", r_nvs, 14);
    chk("A_line0", 32'(r_bits[7:0]), 32'h00CC);
    chk("A_line2", 32'(r_bits[23:16]), 32'h0033);
    chk("A_frame_cnt", 32'(vif.frame_cnt), 1);

    // Single dot; a mid-frame select change must not disturb it.
    pattern_sel = 3'd3;
    measure_frame(-1, 3'd0, -1);
    chk("B_period", r_done_at, 125);
    measure_frame(30, 3'd1, -1);
    chk("B_dot_count", r_nones, 1);
    chk("B_dot_idx19", 32'(r_bits[19]), 1);
    chk("B_frame_cnt", 32'(vif.frame_cnt), 3);

    // All ones to frame end despite change to 7, then reserved code gives zeros.
    measure_frame(20, 3'd7, -1);
    chk("C_ones", r_nones, 48);
    measure_frame(10, 3'd4, -1);
    chk("C_zeros", r_nones, 0);

    // LFSR frame, enable dropped around line 3: frame completes then idles.
    measure_frame(-1, 3'd0, 26);
    chk("D_lfsr_first4", 32'(r_bits[3:0]), 32'h1);
    chk("D_nvalid", r_nvalid, 48);
    chk("D_done_at", r_done_at, 125);
    chk("D_frame_cnt", 32'(vif.frame_cnt), 6);
    tick();
    chk("D_busy_low", 32'(vif.busy), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vif.data_out_valid || vif.frame_done) nv++;
    end
    chk("D_idle_quiet", nv, 0);
    chk("D_frame_cnt_hold", 32'(vif.frame_cnt), 6);

    // Enable low for exactly the final cycle of a frame.
    pattern_sel = 3'd1; enable = 1'b1;
    measure_frame(-1, 3'd0, -1);
    chk("E_first_valid", r_first_valid, 2);
    repeat (125) tick();
    enable = 1'b0;
    tick();
    chk("E_last_done", 32'(vif.frame_done), 1);
    chk("E_frame_cnt", 32'(vif.frame_cnt), 8);
    enable = 1'b1;
    tick();
    chk("E_busy_low", 32'(vif.busy), 0);
    chk("E_valid_low", 32'(vif.data_out_valid), 0);
    measure_frame(-1, 3'd0, -1);
    chk("E_restart_valid", r_first_valid, 1);
    chk("E_restart_done", r_done_at, 126);

    // Reset mid-line with enable held high.
    repeat (40) tick();
    reset_p = 1'b1;
    tick();
    chk("F_cnt_cleared", 32'(vif.frame_cnt), 0);
    chk("F_busy", 32'(vif.busy), 0);
    chk("F_valid", 32'(vif.data_out_valid), 0);
    chk("F_hs", 32'(vif.data_out_hs), 0);
    reset_p = 1'b0;
    measure_frame(-1, 3'd0, -1);
    chk("F_first_valid", r_first_valid, 2);
    chk("F_done_at", r_done_at, 127);
    chk("F_frame_cnt", 32'(vif.frame_cnt), 1);

    // Randomized enable / pattern / reset traffic, checked by the model.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (enable ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 19) == 0)) enable = ~enable;
      if ($urandom_range(0, 29) == 0) pattern_sel = 3'($urandom_range(0, 7));
      reset_p = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset_p = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
